car_ignition_ctrl: RTL and testbench

- Controller for the car-key serial datapath: receives the key bit stream LSB-first, compares it with the stored key and sequences engine start/stop.
- Counts failed attempts and locks out after MAX_TRIES consecutive failures.
- Sits between the key-stream shifter and the LED indicators in top; runs on clk_2.

---
 rtl/car_key_pkg.sv | 19 +
 rtl/car_ignition_ctrl_if.sv | 25 ++
 rtl/key_shift_rx.sv | 31 +++
 rtl/car_ignition_ctrl.sv | 137 +++++++++++++
 tb/tb_car_ignition_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_key_pkg.sv
// rtl/car_key_pkg.sv - shared types and constants for the car ignition controller
package car_key_pkg;

    localparam int NBITS_STREAM = 4;
    localparam logic [NBITS_STREAM-1:0] KEY_VALUE = 4'b1101;
    localparam int MAX_TRIES = 3;
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_CYCLES = 8;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int CNT_W = $clog2(NBITS_STREAM + 1);

    typedef enum logic [2:0] {IDLE, RECV, CHECK, ON, LOCK} ign_state_t;

    // Failure count holds at MAX_TRIES instead of wrapping.
    function automatic logic [TRIES_W-1:0] tries_inc(input logic [TRIES_W-1:0] t);
        return (t == TRIES_W'(MAX_TRIES)) ? t : t + 1'b1;
    endfunction

endpackage

// File: rtl/car_ignition_ctrl_if.sv
// rtl/car_ignition_ctrl_if.sv - key-stream inputs and status outputs of the ignition controller
interface car_ignition_ctrl_if;
    import car_key_pkg::*;

    logic               start;
    logic               bit_valid;
    logic               bit_in;
    logic               stop;
    logic               engine_on;
    logic               busy;
    logic               fail;
    logic               locked;
    logic [TRIES_W-1:0] tries;

    modport master (
        output start, bit_valid, bit_in, stop,
        input  engine_on, busy, fail, locked, tries
    );

    modport slave (
        input  start, bit_valid, bit_in, stop,
        output engine_on, busy, fail, locked, tries
    );

endinterface

// File: rtl/key_shift_rx.sv
// rtl/key_shift_rx.sv - LSB-first serial-to-parallel key shifter with bit counter
module key_shift_rx
    import car_key_pkg::*;
(
    input  logic                    clk_2,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic                    bit_in,
    output logic [NBITS_STREAM-1:0] data,
    output logic                    full
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            data <= '0;
        end else if (clear) begin
            cnt  <= '0;
            data <= '0;
        end else if (shift_en && !full) begin
            data <= {bit_in, data[NBITS_STREAM-1:1]};
            cnt  <= cnt + 1'b1;
        end
    end

    assign full = (cnt == CNT_W'(NBITS_STREAM));

endmodule

// File: rtl/car_ignition_ctrl.sv
// rtl/car_ignition_ctrl.sv - key check and engine start/stop sequencer
// Optional timed lockout exit: CAR_IGNITION_LOCKOUT_TIMER_EN.
module car_ignition_ctrl
    import car_key_pkg::*;
(
    input  logic                clk_2,
    input  logic                reset,
    car_ignition_ctrl_if.slave  bus
);

    ign_state_t state_q, state_d;

    logic               engine_on_q, engine_on_d;
    logic               fail_q, fail_d;
    logic               locked_q, locked_d;
    logic [TRIES_W-1:0] tries_q, tries_d;

    logic                    rx_clear;
    logic                    rx_shift;
    logic                    rx_full;
    logic [NBITS_STREAM-1:0] rx_data;

`ifdef CAR_IGNITION_LOCKOUT_TIMER_EN
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

    key_shift_rx u_rx (
        .clk_2    (clk_2),
        .reset    (reset),
        .clear    (rx_clear),
        .shift_en (rx_shift),
        .bit_in   (bus.bit_in),
        .data     (rx_data),
        .full     (rx_full)
    );

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            engine_on_q <= 1'b0;
            fail_q      <= 1'b0;
            locked_q    <= 1'b0;
            tries_q     <= '0;
`ifdef CAR_IGNITION_LOCKOUT_TIMER_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            engine_on_q <= engine_on_d;
            fail_q      <= fail_d;
            locked_q    <= locked_d;
            tries_q     <= tries_d;
`ifdef CAR_IGNITION_LOCKOUT_TIMER_EN
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        engine_on_d = engine_on_q;
        fail_d      = 1'b0;
        locked_d    = locked_q;
        tries_d     = tries_q;
        rx_clear    = 1'b0;
        rx_shift    = 1'b0;
`ifdef CAR_IGNITION_LOCKOUT_TIMER_EN
        lock_cnt_d  = lock_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.stop && bus.start) begin
                    state_d  = RECV;
                    rx_clear = 1'b1;
                end
            end
            RECV: begin
                // Priority: abort, then restart (drops any bit this cycle), then hand-off.
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    rx_clear = 1'b1;
                end else if (rx_full) begin
                    state_d = CHECK;
                end else begin
                    rx_shift = bus.bit_valid;
                end
            end
            CHECK: begin
                if (rx_data == KEY_VALUE) begin
                    state_d     = ON;
                    engine_on_d = 1'b1;
                    tries_d     = '0;
                end else begin
                    fail_d  = 1'b1;
                    tries_d = tries_inc(tries_q);
                    if (tries_inc(tries_q) == TRIES_W'(MAX_TRIES)) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
`ifdef CAR_IGNITION_LOCKOUT_TIMER_EN
                        lock_cnt_d = LOCK_W'(LOCK_CYCLES - 1);
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ON: begin
                if (bus.stop) begin
                    state_d     = IDLE;
                    engine_on_d = 1'b0;
                end
            end
            LOCK: begin
`ifdef CAR_IGNITION_LOCKOUT_TIMER_EN
                if (lock_cnt_q == '0) begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    tries_d  = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
`else
                state_d = LOCK;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.engine_on = engine_on_q;
    assign bus.fail      = fail_q;
    assign bus.locked    = locked_q;
    assign bus.tries     = tries_q;
    assign bus.busy      = (state_q == RECV) || (state_q == CHECK);

endmodule

// File: tb/tb_car_ignition_ctrl.sv
// tb/tb_car_ignition_ctrl.sv - scoreboard bench for car_ignition_ctrl
module tb_car_ignition_ctrl;

    typedef struct packed {
        logic       engine_on;
        logic       fail;
        logic       locked;
        logic [1:0] tries;
    } exp_t;

    localparam logic [3:0] GOOD_KEY = 4'b1101;
    localparam logic [3:0] BAD_KEY  = 4'b1100;

    logic clk_2;
    logic reset;

    car_ignition_ctrl_if bus ();

    car_ignition_ctrl dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    logic       m_on;
    logic       m_locked;
    logic [1:0] m_tries;

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_on = 1'b0;
        m_locked = 1'b0;
        m_tries = 2'd0;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_valid = 1'b1;
        bus.bit_in = b;
        tick();
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Reference behaviour of one complete key attempt.
    task automatic predict(input logic [3:0] key);
        exp_t e;
        if (m_locked) begin
            e = '{engine_on: 1'b0, fail: 1'b0, locked: 1'b1, tries: m_tries};
        end else if (key == GOOD_KEY) begin
            m_on = 1'b1;
            m_tries = 2'd0;
            e = '{engine_on: 1'b1, fail: 1'b0, locked: 1'b0, tries: 2'd0};
        end else begin
            if (m_tries != 2'd3) m_tries = m_tries + 2'd1;
            if (m_tries == 2'd3) m_locked = 1'b1;
            e = '{engine_on: 1'b0, fail: 1'b1, locked: m_locked, tries: m_tries};
        end
        sb.push_back(e);
    endtask

    task automatic finish_attempt(input string name);
        exp_t e;
        exp_t got;
        tick();
        vectors++;
        if ({bus.engine_on, bus.fail} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_early: engine_on,fail=%b required 00", name, {bus.engine_on, bus.fail});
        end
        tick();
        got = {bus.engine_on, bus.fail, bus.locked, bus.tries};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s_sb: scoreboard empty, got %b", name, got);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s_result: on,fail,locked,tries=%b required %b", name, got, e);
            end
        end
        tick();
        vectors++;
        if (bus.fail !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_fail_pulse: fail=%b required 0", name, bus.fail);
        end
    endtask

    task automatic attempt(input logic [3:0] key, input string name);
        pulse_start();
        predict(key);
        for (int i = 0; i < 4; i++) send_bit(key[i]);
        finish_attempt(name);
    endtask

    task automatic ensure_off();
        if (m_on) begin
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            m_on = 1'b0;
            vectors++;
            if (bus.engine_on !== 1'b0) begin
                miscompares++;
                $display("FAIL stop_on: engine_on=%b required 0", bus.engine_on);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.engine_on, bus.busy, bus.fail, bus.locked, bus.tries} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_state: outputs=%b required 000000",
                     {bus.engine_on, bus.busy, bus.fail, bus.locked, bus.tries});
        end
        reset = 1'b1;
        m_on = 1'b0;
        m_locked = 1'b0;
        m_tries = 2'd0;
        tick();
    endtask

    task automatic test_good_key();
        attempt(GOOD_KEY, "good_key");
    endtask

    task automatic test_bad_then_good();
        ensure_off();
        attempt(BAD_KEY, "bad_key");
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_key_idle: busy=%b required 0", bus.busy);
        end
        attempt(GOOD_KEY, "good_after_bad");
    endtask

    task automatic test_gaps_restart();
        ensure_off();
        pulse_start();
        predict(GOOD_KEY);
        send_bit(1'b1);
        tick();
        send_bit(1'b0);
        tick();
        tick();
        send_bit(1'b1);
        send_bit(1'b1);
        finish_attempt("gaps");
        ensure_off();
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b0);
        bus.start = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick();
        tick();
        vectors++;
        if ({bus.engine_on, bus.busy, bus.fail} !== 3'b010) begin
            miscompares++;
            $display("FAIL restart_3bits: on,busy,fail=%b required 010", {bus.engine_on, bus.busy, bus.fail});
        end
        predict(GOOD_KEY);
        send_bit(1'b1);
        finish_attempt("restart");
    endtask

    task automatic test_stop_recv();
        ensure_off();
        attempt(BAD_KEY, "pre_stop_bad");
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        vectors++;
        if ({bus.engine_on, bus.busy, bus.fail, bus.tries} !== {3'b000, m_tries}) begin
            miscompares++;
            $display("FAIL stop_recv: on,busy,fail,tries=%b required %b",
                     {bus.engine_on, bus.busy, bus.fail, bus.tries}, {3'b000, m_tries});
        end
        tick();
        tick();
        vectors++;
        if ({bus.busy, bus.fail} !== 2'b00) begin
            miscompares++;
            $display("FAIL stop_recv_settle: busy,fail=%b required 00", {bus.busy, bus.fail});
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b1);
        vectors++;
        if ({bus.busy, bus.tries} !== {1'b1, m_tries}) begin
            miscompares++;
            $display("FAIL async_pre: busy,tries=%b required %b", {bus.busy, bus.tries}, {1'b1, m_tries});
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.engine_on, bus.busy, bus.fail, bus.locked, bus.tries} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset: outputs=%b required 000000",
                     {bus.engine_on, bus.busy, bus.fail, bus.locked, bus.tries});
        end
        tick();
        reset = 1'b1;
        m_on = 1'b0;
        m_locked = 1'b0;
        m_tries = 2'd0;
        attempt(GOOD_KEY, "after_async");
    endtask

    task automatic test_on_stop_start();
        bus.stop = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.start = 1'b0;
        m_on = 1'b0;
        vectors++;
        if ({bus.engine_on, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL on_stop_start: on,busy=%b required 00", {bus.engine_on, bus.busy});
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL on_stop_no_attempt: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_lockout();
        int n;
        apply_reset();
        attempt(BAD_KEY, "lock_bad1");
        attempt(BAD_KEY, "lock_bad2");
        attempt(BAD_KEY, "lock_bad3");
`ifdef CAR_IGNITION_LOCKOUT_TIMER_EN
        n = 0;
        while (bus.locked === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 7 || bus.tries !== 2'd0) begin
            miscompares++;
            $display("FAIL lock_timer: cycles=%0d tries=%0d required 7 and 0", n, bus.tries);
        end
        m_locked = 1'b0;
        m_tries = 2'd0;
        attempt(GOOD_KEY, "after_lock");
`else
        attempt(GOOD_KEY, "locked_key");
        n = 0;
        repeat (10) begin
            tick();
            if (bus.locked === 1'b1 && bus.engine_on === 1'b0) n++;
        end
        vectors++;
        if (n !== 10) begin
            miscompares++;
            $display("FAIL lock_hold: locked cycles=%0d required 10", n);
        end
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        m_on = 1'b0;
        m_locked = 1'b0;
        m_tries = 2'd0;

        test_reset();
        test_good_key();
        test_bad_then_good();
        test_gaps_restart();
        test_stop_recv();
        test_async_reset();
        test_on_stop_start();
        test_lockout();

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
